// File: rtl/cdec8_result_dump_pkg.sv
// Shared types, ASCII constants and nibble formatter for the CDEC8 result dumper.
package cdec8_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, SEND, NEXT, DONE} dump_state_t;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? ASC_0 + {4'h0, n} : ASC_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/cdec8_result_dump_if.sv
// Result-window bus between the CDEC8 core, the dumper and the UART line.
interface cdec8_result_dump_if;
  logic       endseq;
  logic [7:0] resad;
  logic [7:0] resdt;
  logic       txd;
  logic       busy;
  logic       done;

  modport master (input endseq, resdt, output resad, txd, busy, done);
  modport slave  (output endseq, resdt, input resad, txd, busy, done);
endinterface

// File: rtl/cdec8_result_dump_uart_tx.sv
// 8N1 UART transmitter; tx_ready is already high in the last stop-bit cycle.
module cdec8_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;
  logic          bit_end;

  assign bit_end  = (baud_cnt == BAUD_MAX);
  // Accepting a new byte during the final stop cycle keeps bytes gap-free.
  assign tx_ready = !active || (bit_end && bit_idx == 4'd9);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '1;
      txd      <= 1'b1;
    end else if (tx_start && tx_ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= {1'b1, tx_data};
      txd      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          txd     <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdec8_result_dump.sv
// Dumps the CDEC8 result window over UART after endseq rises.
// Define CDEC8_DUMP_HEX_EN for ASCII hex records instead of raw bytes.
module cdec8_result_dump #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  FIRST_AD     = 8'h00,
  parameter logic [7:0]  LAST_AD      = 8'h1F,
  parameter int unsigned READ_WAIT    = 2
) (
  input logic                 clock,
  input logic                 reset_N,
  cdec8_result_dump_if.master bus
);
  import cdec8_pkg::*;

  if (FIRST_AD > LAST_AD || READ_WAIT < 1 || READ_WAIT > 15) begin : g_cfg_check
    $error("cdec8_result_dump: illegal FIRST_AD/LAST_AD/READ_WAIT");
  end

`ifdef CDEC8_DUMP_HEX_EN
  localparam logic [1:0] NB = 2'd3;
`else
  localparam logic [1:0] NB = 2'd1;
`endif
  localparam logic [3:0] RW_LAST = 4'(READ_WAIT - 1);

  dump_state_t state, next;
  logic        es_r;
  logic [3:0]  cnt;
  logic [7:0]  data_r;
  logic [7:0]  resad_q;
  logic [1:0]  byte_idx;
  logic        tx_start;
  logic        tx_ready;
  logic [7:0]  tx_data;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next     = state;
    tx_start = 1'b0;
    case (state)
      IDLE:    if (bus.endseq && !es_r) next = SETTLE;
      SETTLE:  if (cnt == RW_LAST) next = SAMPLE;
      SAMPLE:  next = SEND;
      SEND: begin
        if (byte_idx != NB) tx_start = tx_ready;
        else if (tx_ready)  next = NEXT;
      end
      NEXT:    next = (resad_q == LAST_AD) ? DONE : SETTLE;
      DONE:    if (!bus.endseq) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // es_r resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      es_r     <= 1'b1;
      cnt      <= '0;
      data_r   <= '0;
      resad_q  <= FIRST_AD;
      byte_idx <= '0;
    end else begin
      es_r <= bus.endseq;
      if (state != SETTLE) cnt <= '0;
      else                 cnt <= cnt + 4'd1;
      if (state == IDLE && next == SETTLE)      resad_q <= FIRST_AD;
      else if (state == NEXT && next == SETTLE) resad_q <= resad_q + 8'd1;
      if (state == SAMPLE) begin
        data_r   <= bus.resdt;
        byte_idx <= '0;
      end else if (tx_start) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  always_comb begin
`ifdef CDEC8_DUMP_HEX_EN
    case (byte_idx)
      2'd0:    tx_data = nib2asc(data_r[7:4]);
      2'd1:    tx_data = nib2asc(data_r[3:0]);
      default: tx_data = (resad_q == LAST_AD) ? ASC_LF : ASC_SP;
    endcase
`else
    tx_data = data_r;
`endif
  end

  assign bus.resad = resad_q;
  assign bus.busy  = (state == SETTLE) || (state == SAMPLE) || (state == SEND) || (state == NEXT);
  assign bus.done  = (state == DONE);

  cdec8_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock    (clock),
    .reset_N  (reset_N),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .txd      (bus.txd)
  );

endmodule

// File: tb/tb_cdec8_result_dump.sv
// Randomised self-checking bench for cdec8_result_dump (three address windows, one UART decoder each).
module tb_cdec8_result_dump;
  localparam int CPB = 4;
  localparam int RW  = 2;
`ifdef CDEC8_DUMP_HEX_EN
  localparam int NB = 3;
`else
  localparam int NB = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       es [3];
  logic [7:0] mem [3][256];
  logic       busy_v [3];
  logic       done_v [3];
  logic       txd_v [3];
  logic [7:0] resad_v [3];
  logic [7:0] rx_mem [3][64];
  int         rx_cnt [3];
  int         frame_err = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  cdec8_result_dump_if bus0 ();
  cdec8_result_dump_if bus1 ();
  cdec8_result_dump_if bus2 ();

  assign bus0.endseq = es[0];
  assign bus1.endseq = es[1];
  assign bus2.endseq = es[2];
  assign bus0.resdt  = mem[0][bus0.resad];
  assign bus1.resdt  = mem[1][bus1.resad];
  assign bus2.resdt  = mem[2][bus2.resad];
  assign busy_v[0] = bus0.busy;  assign busy_v[1] = bus1.busy;  assign busy_v[2] = bus2.busy;
  assign done_v[0] = bus0.done;  assign done_v[1] = bus1.done;  assign done_v[2] = bus2.done;
  assign txd_v[0]  = bus0.txd;   assign txd_v[1]  = bus1.txd;   assign txd_v[2]  = bus2.txd;
  assign resad_v[0] = bus0.resad; assign resad_v[1] = bus1.resad; assign resad_v[2] = bus2.resad;

  cdec8_result_dump #(.CLKS_PER_BIT(CPB), .FIRST_AD(8'h00), .LAST_AD(8'h03), .READ_WAIT(RW))
    dut0 (.clock(clk), .reset_N(rst_n), .bus(bus0.master));
  cdec8_result_dump #(.CLKS_PER_BIT(CPB), .FIRST_AD(8'hFE), .LAST_AD(8'hFF), .READ_WAIT(RW))
    dut1 (.clock(clk), .reset_N(rst_n), .bus(bus1.master));
  cdec8_result_dump #(.CLKS_PER_BIT(CPB), .FIRST_AD(8'h05), .LAST_AD(8'h05), .READ_WAIT(RW))
    dut2 (.clock(clk), .reset_N(rst_n), .bus(bus2.master));

  function automatic int first_of(input int sel);
    case (sel) 0: return 0; 1: return 254; default: return 5; endcase
  endfunction

  function automatic int last_of(input int sel);
    case (sel) 0: return 3; 1: return 255; default: return 5; endcase
  endfunction

  // Record cost: settle + sample + NB frames + handshake/next.
  function automatic int exp_busy(input int sel);
    return (last_of(sel) - first_of(sel) + 1) * (RW + 3 + NB * 10 * CPB);
  endfunction

  // Mid-bit sampling UART receiver.
  task automatic uart_rx(input int sel);
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (txd_v[sel] === 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        #1 if (txd_v[sel] !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 b[i] = txd_v[sel];
        end
        repeat (CPB) @(posedge clk);
        #1 if (txd_v[sel] !== 1'b1) frame_err++;
        if (rx_cnt[sel] < 64) rx_mem[sel][rx_cnt[sel]] = b;
        rx_cnt[sel]++;
      end
    end
  endtask

  initial uart_rx(0);
  initial uart_rx(1);
  initial uart_rx(2);

  // Raises endseq and measures one dump; optional endseq drop/rise at given cycles.
  task automatic run_dump(input int sel, input int drop_at, input int rise_at,
                          output int lat, output int busy_cyc, output int oor,
                          output bit tmo, output bit done_end);
    lat = -1; busy_cyc = 0; oor = 0; tmo = 1'b1; done_end = 1'b0;
    @(negedge clk);
    rx_cnt[sel] = 0;
    es[sel] = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (busy_v[sel] === 1'b1) begin
        busy_cyc++;
        if (lat < 0) lat = k;
        if (int'(resad_v[sel]) < first_of(sel) || int'(resad_v[sel]) > last_of(sel)) oor++;
      end else if (lat >= 0) begin
        tmo = 1'b0;
        done_end = done_v[sel];
        break;
      end
      if (k == drop_at) es[sel] = 1'b0;
      if (k == rise_at) es[sel] = 1'b1;
    end
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Builds the expected byte stream from the memory image and diffs it against the decoder.
  task automatic compare_stream(input int sel, output int bad, output int n_exp, output int idx,
                                output logic [7:0] got, output logic [7:0] want);
    string hexd = "0123456789ABCDEF";
    logic [7:0] e [$];
    logic [7:0] d;
    e = {};
    for (int a = first_of(sel); a <= last_of(sel); a++) begin
      d = mem[sel][a];
      if (NB == 1) e.push_back(d);
      else begin
        e.push_back(hexd[d[7:4]]);
        e.push_back(hexd[d[3:0]]);
        e.push_back((a == last_of(sel)) ? 8'h0A : 8'h20);
      end
    end
    n_exp = e.size();
    bad = (rx_cnt[sel] == n_exp) ? 0 : 1;
    idx = -1; got = '0; want = '0;
    for (int i = 0; i < n_exp && i < rx_cnt[sel]; i++)
      if (rx_mem[sel][i] !== e[i]) begin
        bad++;
        if (idx < 0) begin idx = i; got = rx_mem[sel][i]; want = e[i]; end
      end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) es[s] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (txd_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || resad_v[s] !== 8'(first_of(s))) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: txd=%b busy=%b done=%b resad=%h, required 1 0 0 %h",
                 s, txd_v[s], busy_v[s], done_v[s], resad_v[s], 8'(first_of(s)));
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++)
        if (txd_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || resad_v[s] !== 8'(first_of(s))) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_level_no_dump: %0d idle deviations, required 0", bad);
    end
    for (int s = 0; s < 3; s++) es[s] = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_raw_dump();
    int lat, bc, oor, bad, ne, idx;
    bit tmo, de;
    logic [7:0] g, w;
    for (int a = 0; a < 256; a++) mem[0][a] = 8'(a + 16);
    run_dump(0, -1, -1, lat, bc, oor, tmo, de);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL dump_timeout: busy never ended"); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dump_latency: got %0d cycles, required 1", lat); end
    n_checks++;
    if (bc < exp_busy(0) - 1 || bc > exp_busy(0) + 1) begin
      n_fail++; $display("FAIL dump_busy_len: got %0d cycles, required %0d +-1", bc, exp_busy(0));
    end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL dump_done: got %b, required 1", de); end
    n_checks++; if (oor !== 0) begin n_fail++; $display("FAIL dump_addr_range: %0d out of range, required 0", oor); end
    compare_stream(0, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL dump_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[0], ne, idx, g, w);
    end
    n_checks++; if (done_v[0] !== 1'b1) begin n_fail++; $display("FAIL dump_done_hold: got %b, required 1", done_v[0]); end
    es[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL dump_done_clear: got %b, required 0", done_v[0]); end
  endtask

  task automatic test_single_record();
    int lat, bc, oor, bad, ne, idx;
    bit tmo, de;
    logic [7:0] g, w;
    mem[2][5] = 8'hA7;
    run_dump(2, -1, -1, lat, bc, oor, tmo, de);
    compare_stream(2, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL single_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[2], ne, idx, g, w);
    end
    n_checks++;
    if (bc < exp_busy(2) - 1 || bc > exp_busy(2) + 1) begin
      n_fail++; $display("FAIL single_busy_len: got %0d, required %0d +-1", bc, exp_busy(2));
    end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b, required 1", de); end
    es[2] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_top_of_range();
    int lat, bc, oor, bad, ne, idx;
    bit tmo, de;
    logic [7:0] g, w;
    for (int a = 0; a < 256; a++) mem[1][a] = 8'($urandom);
    run_dump(1, -1, -1, lat, bc, oor, tmo, de);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL top_timeout: busy never ended"); end
    n_checks++; if (oor !== 0) begin n_fail++; $display("FAIL top_addr_wrap: %0d out of range, required 0", oor); end
    compare_stream(1, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL top_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[1], ne, idx, g, w);
    end
    n_checks++; if (resad_v[1] !== 8'hFF) begin n_fail++; $display("FAIL top_resad_final: got %h, required ff", resad_v[1]); end
    n_checks++; if (done_v[1] !== 1'b1) begin n_fail++; $display("FAIL top_done: got %b, required 1", done_v[1]); end
    es[1] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_endseq_glitch();
    int lat, bc, oor, bad, ne, idx, extra;
    bit tmo, de;
    logic [7:0] g, w;
    for (int a = 0; a < 256; a++) mem[0][a] = 8'($urandom);
    run_dump(0, 20, 25, lat, bc, oor, tmo, de);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL glitch_timeout: busy never ended"); end
    compare_stream(0, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[0], ne, idx, g, w);
    end
    extra = 0;
    repeat (300) begin @(posedge clk); #1; if (busy_v[0] === 1'b1) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL glitch_no_redump: %0d busy cycles, required 0", extra); end
    n_checks++; if (done_v[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_done_hold: got %b, required 1", done_v[0]); end
    es[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_done_clear: got %b, required 0", done_v[0]); end
    for (int a = 0; a < 256; a++) mem[0][a] = 8'($urandom);
    run_dump(0, -1, -1, lat, bc, oor, tmo, de);
    compare_stream(0, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rearm_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[0], ne, idx, g, w);
    end
    es[0] = 1'b0;
    repeat (3) @(posedge clk);
    run_dump(0, 10, -1, lat, bc, oor, tmo, de);
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL short_done_seen: got %b, required 1", de); end
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL short_done_clear: got %b, required 0", done_v[0]); end
  endtask

  task automatic test_reset_mid_frame();
    int k, lat, bc, oor, bad, ne, idx;
    bit tmo, de;
    logic [7:0] g, w;
    for (int a = 0; a < 256; a++) mem[0][a] = 8'h00;
    @(negedge clk) es[0] = 1'b1;
    k = 0;
    while (busy_v[0] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    repeat (13) @(posedge clk);
    #2;
    n_checks++; if (txd_v[0] !== 1'b0) begin n_fail++; $display("FAIL midframe_line_low: txd=%b, required 0", txd_v[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || resad_v[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_async_reset: txd=%b busy=%b done=%b resad=%h, required 1 0 0 00",
               txd_v[0], busy_v[0], done_v[0], resad_v[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    k = 0;
    repeat (30) begin @(posedge clk); #1; if (busy_v[0] === 1'b1) k++; end
    n_checks++; if (k !== 0) begin n_fail++; $display("FAIL midframe_no_level_trigger: %0d busy cycles, required 0", k); end
    es[0] = 1'b0;
    repeat (60) @(posedge clk);
    for (int a = 0; a < 256; a++) mem[0][a] = 8'($urandom);
    run_dump(0, -1, -1, lat, bc, oor, tmo, de);
    compare_stream(0, bad, ne, idx, g, w);
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL postreset_stream: %0d errors, got %0d bytes need %0d, byte %0d got %h need %h", bad, rx_cnt[0], ne, idx, g, w);
    end
    n_checks++;
    if (bc < exp_busy(0) - 1 || bc > exp_busy(0) + 1) begin
      n_fail++; $display("FAIL postreset_busy_len: got %0d, required %0d +-1", bc, exp_busy(0));
    end
    es[0] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      es[s] = 1'b1;
      rx_cnt[s] = 0;
      for (int a = 0; a < 256; a++) mem[s][a] = 8'($urandom);
    end
    test_reset();
    test_raw_dump();
    test_single_record();
    test_top_of_range();
    test_endseq_glitch();
    test_reset_mid_frame();
    n_checks++;
    if (frame_err !== 0) begin n_fail++; $display("FAIL uart_framing: %0d bad start/stop bits, required 0", frame_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
